// File: rtl/sram_axi_bridge.sv
// Bridges the CPU instruction and data SRAM-like ports onto one AXI3-subset master.
// Latency: addr_ok to data_ok is 3 cycles minimum; each AXI wait cycle adds 1.
// Backpressure: one transaction in flight; addr_ok stays low until the previous data_ok has gone.
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    // instruction port
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // AXI read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [3:0]  bid,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {IDLE, RREQ, RDATA, WREQ, WRESP, RESP} state_t;

    state_t      state, state_nxt;
    logic        own_data;   // 1 when the data port owns the current transaction
    logic [3:0]  id_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        aw_done;
    logic        w_done;

    // Response IDs are not checked since only one transaction is ever outstanding.
    logic        unused_ok;
    assign unused_ok = ^{rid, bid};

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and handshake outputs; every output derives from registered state
    // so AXI valids never depend combinationally on AXI readies.
    always_comb begin
        state_nxt    = state;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state)
            IDLE: begin
                // resetn gating keeps addr_ok low while reset is held.
                if (data_req && resetn) begin
                    data_addr_ok = 1'b1;
                    state_nxt    = data_wr ? WREQ : RREQ;
                end else if (inst_req && resetn) begin
                    inst_addr_ok = 1'b1;
                    state_nxt    = RREQ;
                end
            end
            RREQ: begin
                arvalid = 1'b1;
                if (arready) state_nxt = RDATA;
            end
            RDATA: begin
                rready = 1'b1;
                if (rvalid) state_nxt = RESP;
            end
            WREQ: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) state_nxt = WRESP;
            end
            WRESP: begin
                bready = 1'b1;
                if (bvalid) state_nxt = RESP;
            end
            RESP: begin
                inst_data_ok = !own_data;
                data_data_ok = own_data;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, read data capture and write handshake tracking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            own_data <= 1'b0;
            id_q     <= 4'd0;
            addr_q   <= 32'd0;
            size_q   <= 2'd0;
            wstrb_q  <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            if (data_addr_ok || inst_addr_ok) begin
                own_data <= data_addr_ok;
                id_q     <= data_addr_ok ? DATA_ID : INST_ID;
                addr_q   <= data_addr_ok ? data_addr : inst_addr;
                size_q   <= data_addr_ok ? data_size : 2'd2;
                wstrb_q  <= data_wstrb;
                wdata_q  <= data_wdata;
                rdata_q  <= 32'd0;    // writes return zero
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
            end
            if (rready && rvalid)   rdata_q <= rdata;
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
        end
    end

    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign awid    = id_q;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = 2'b01;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;

    assign inst_rdata = inst_data_ok ? rdata_q : 32'd0;
    assign data_rdata = data_data_ok ? rdata_q : 32'd0;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: inputs change on the falling edge,
// outputs are sampled 1 ns later, so each "cycle" below is one clock period.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic [3:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    sram_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
        data_addr = 32'd0; data_wstrb = 4'd0; data_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd0; bvalid = 1'b0;

        // reset state
        #1;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid",  32'(wvalid),  32'd0);
        chk("rst_ready",   32'({rready, bready}), 32'd0);
        chk("rst_ok",      32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
        tick(); resetn = 1'b1;

        // 1: instruction read, zero-wait slave
        tick(); inst_req = 1'b1; inst_addr = 32'h1c000000;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h02800c0c; #1;
        chk("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t1_data_addr_ok", 32'(data_addr_ok), 32'd0);
        tick(); inst_req = 1'b0; inst_addr = 32'd0; #1;
        chk("t1_arvalid", 32'(arvalid), 32'd1);
        chk("t1_araddr",  araddr, 32'h1c000000);
        chk("t1_arid",    32'(arid), 32'd0);
        chk("t1_arsize",  32'(arsize), 32'd2);
        chk("t1_arlen",   32'(arlen), 32'd0);
        chk("t1_arburst", 32'(arburst), 32'd1);
        tick(); #1;
        chk("t1_rready",  32'(rready), 32'd1);
        chk("t1_ar_drop", 32'(arvalid), 32'd0);
        tick(); #1;
        chk("t1_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t1_rdata",   inst_rdata, 32'h02800c0c);
        chk("t1_dport_quiet", 32'(data_data_ok), 32'd0);
        tick(); #1;
        chk("t1_ok_pulse", 32'(inst_data_ok), 32'd0);
        chk("t1_rdata_idle", inst_rdata, 32'd0);

        // 2: simultaneous requests, data port wins
        tick(); inst_req = 1'b1; inst_addr = 32'h1c000010;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1c008000;
        rdata = 32'h11112222; #1;
        chk("t2_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("t2_inst_blocked", 32'(inst_addr_ok), 32'd0);
        tick(); data_req = 1'b0; #1;
        chk("t2_arid",   32'(arid), 32'd1);
        chk("t2_araddr", araddr, 32'h1c008000);
        chk("t2_no_inst_ok", 32'(inst_addr_ok), 32'd0);
        tick(); #1;
        chk("t2_rready", 32'(rready), 32'd1);
        tick(); rdata = 32'h33334444; #1;
        chk("t2_data_ok",   32'(data_data_ok), 32'd1);
        chk("t2_rdata",     data_rdata, 32'h11112222);
        chk("t2_inst_wait", 32'(inst_addr_ok), 32'd0);
        chk("t2_inst_ok_quiet", 32'(inst_data_ok), 32'd0);
        tick(); #1;
        chk("t2_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        tick(); inst_req = 1'b0; #1;
        chk("t2_inst_araddr", araddr, 32'h1c000010);
        chk("t2_inst_arid",   32'(arid), 32'd0);
        tick(); tick(); #1;
        chk("t2_inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t2_inst_rdata",   inst_rdata, 32'h33334444);

        // 3: byte write, awready 3 cycles late, wready immediate
        tick(); arready = 1'b0; rvalid = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h1c008003;
        data_wstrb = 4'b1000; data_wdata = 32'hab000000;
        awready = 1'b0; wready = 1'b1; #1;
        chk("t3_addr_ok", 32'(data_addr_ok), 32'd1);
        tick(); data_req = 1'b0; data_wr = 1'b0; data_wdata = 32'd0; data_wstrb = 4'd0; #1;
        chk("t3_awvalid_c1", 32'(awvalid), 32'd1);
        chk("t3_wvalid_c1",  32'(wvalid), 32'd1);
        chk("t3_awsize",  32'(awsize), 32'd0);
        chk("t3_awaddr",  awaddr, 32'h1c008003);
        chk("t3_awid",    32'(awid), 32'd1);
        chk("t3_wstrb",   32'(wstrb), 32'h8);
        chk("t3_wdata",   wdata, 32'hab000000);
        chk("t3_wlast",   32'(wlast), 32'd1);
        chk("t3_awlen",   32'(awlen), 32'd0);
        chk("t3_awburst", 32'(awburst), 32'd1);
        for (int c = 2; c <= 4; c++) begin
            tick(); awready = (c == 4); #1;
            chk("t3_awvalid_held", 32'(awvalid), 32'd1);
            chk("t3_wvalid_drop",  32'(wvalid), 32'd0);
        end
        tick(); awready = 1'b0; wready = 1'b0; #1;
        chk("t3_aw_drop", 32'(awvalid), 32'd0);
        chk("t3_bready",  32'(bready), 32'd1);
        chk("t3_early_ok", 32'(data_data_ok), 32'd0);
        tick(); bvalid = 1'b1; #1;
        chk("t3_bready_wait", 32'(bready), 32'd1);
        chk("t3_no_ok_yet", 32'(data_data_ok), 32'd0);
        tick(); bvalid = 1'b0; #1;
        chk("t3_data_ok", 32'(data_data_ok), 32'd1);
        chk("t3_wr_rdata", data_rdata, 32'd0);
        tick(); #1;
        chk("t3_ok_pulse", 32'(data_data_ok), 32'd0);

        // 4: read with rvalid 5 cycles late; data_req stays high throughout
        tick(); data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h1c008100;
        arready = 1'b1; rvalid = 1'b0; rdata = 32'h5555aaaa; #1;
        chk("t4_addr_ok", 32'(data_addr_ok), 32'd1);
        for (int c = 1; c <= 7; c++) begin
            tick(); rvalid = (c == 7); #1;
            chk("t4_no_addr_ok", 32'(data_addr_ok), 32'd0);
            chk("t4_no_data_ok", 32'(data_data_ok), 32'd0);
            if (c == 1) chk("t4_arsize", 32'(arsize), 32'd1);
            if (c >= 2) chk("t4_rready", 32'(rready), 32'd1);
        end
        tick(); data_req = 1'b0; rvalid = 1'b0; #1;
        chk("t4_data_ok_c8", 32'(data_data_ok), 32'd1);
        chk("t4_rdata", data_rdata, 32'h5555aaaa);
        chk("t4_no_addr_ok_resp", 32'(data_addr_ok), 32'd0);

        // 5: asynchronous reset while a write is in WREQ
        tick(); arready = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h1c008200;
        data_wstrb = 4'hf; data_wdata = 32'h12345678; #1;
        chk("t5_addr_ok", 32'(data_addr_ok), 32'd1);
        tick(); data_req = 1'b0; data_wr = 1'b0; #1;
        chk("t5_awvalid", 32'(awvalid), 32'd1);
        #1; resetn = 1'b0; #1;
        chk("t5_rst_awvalid", 32'(awvalid), 32'd0);
        chk("t5_rst_wvalid",  32'(wvalid), 32'd0);
        chk("t5_rst_data_ok", 32'(data_data_ok), 32'd0);
        chk("t5_rst_bready",  32'(bready), 32'd0);
        tick(); resetn = 1'b1;
        data_req = 1'b1; data_addr = 32'h1c008300; data_size = 2'd2;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0badf00d; #1;
        chk("t5_idle_addr_ok", 32'(data_addr_ok), 32'd1);
        tick(); data_req = 1'b0; #1;
        chk("t5_araddr", araddr, 32'h1c008300);
        tick(); tick(); #1;
        chk("t5_data_ok", 32'(data_data_ok), 32'd1);
        chk("t5_rdata", data_rdata, 32'h0badf00d);

        // 6: back-to-back instruction reads
        tick(); inst_req = 1'b1; inst_addr = 32'h1c000000; rdata = 32'haaaa0001; #1;
        chk("t6_addr_ok_a", 32'(inst_addr_ok), 32'd1);
        tick(); inst_addr = 32'h1c000004; #1;
        chk("t6_araddr_a", araddr, 32'h1c000000);
        chk("t6_busy", 32'(inst_addr_ok), 32'd0);
        tick(); #1;
        tick(); rdata = 32'hbbbb0002; #1;
        chk("t6_data_ok_a", 32'(inst_data_ok), 32'd1);
        chk("t6_rdata_a", inst_rdata, 32'haaaa0001);
        chk("t6_no_addr_ok_resp", 32'(inst_addr_ok), 32'd0);
        tick(); #1;
        chk("t6_addr_ok_b", 32'(inst_addr_ok), 32'd1);
        tick(); inst_req = 1'b0; #1;
        chk("t6_araddr_b", araddr, 32'h1c000004);
        tick(); tick(); #1;
        chk("t6_data_ok_b", 32'(inst_data_ok), 32'd1);
        chk("t6_rdata_b", inst_rdata, 32'hbbbb0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
